// File: rtl/axonerve_kvs_rtl_adder_ctrl.sv
// axonerve_kvs_rtl_adder_ctrl: per-call transfer sequencer gating an AXI4-Stream into the kvs adder for N beats with generated tlast
// Ports: aclk/areset (sync, active-high); ctrl_* start/beats/constant in, busy/done/err_tlast/beats_done/stall_cycles out;
// adder_constant to adder; s_axis_* upstream slave, m_axis_* adder-facing master (data/keep pass-through, tlast generated).
// Optional: AXONERVE_KVS_ADDER_CTRL_STALL_CNT_EN enables the saturating stall counter; otherwise ctrl_stall_cycles is 0.
module axonerve_kvs_rtl_adder_ctrl #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_ADDER_BIT_WIDTH = 32,
  parameter int C_XFER_SIZE_WIDTH = 32
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            ctrl_start,
  input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_beats,
  input  logic [C_ADDER_BIT_WIDTH-1:0]    ctrl_constant_in,
  output logic                            ctrl_busy,
  output logic                            ctrl_done,
  output logic                            ctrl_err_tlast,
  output logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_beats_done,
  output logic [31:0]                     ctrl_stall_cycles,
  output logic [C_ADDER_BIT_WIDTH-1:0]    adder_constant,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);
  typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [C_XFER_SIZE_WIDTH-1:0] remaining_q, remaining_d, beats_q, beats_d;
  logic [C_ADDER_BIT_WIDTH-1:0] const_q, const_d;
  logic err_q, err_d;
  logic run, beat, start;
  assign run = state_q == RUN;
  assign start = state_q == IDLE && ctrl_start;
  // reset gates the handshake combinationally so nothing is taken in the reset cycle
  assign m_axis_tvalid = run & s_axis_tvalid & ~areset;
  assign s_axis_tready = run & m_axis_tready & ~areset;
  assign m_axis_tlast = run & (remaining_q == C_XFER_SIZE_WIDTH'(1));
  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign beat = m_axis_tvalid & m_axis_tready;
  assign ctrl_busy = state_q != IDLE;
  assign ctrl_done = state_q == DONE;
  assign ctrl_err_tlast = err_q;
  assign ctrl_beats_done = beats_q;
  assign adder_constant = const_q;
  always_comb begin
    state_d = state_q;
    remaining_d = remaining_q;
    beats_d = beats_q;
    const_d = const_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (ctrl_start) begin
        state_d = ctrl_xfer_beats == '0 ? DONE : SETUP;
        remaining_d = ctrl_xfer_beats;
        beats_d = '0;
        err_d = 1'b0;
        const_d = ctrl_xfer_beats == '0 ? const_q : ctrl_constant_in;
      end
      SETUP: state_d = RUN;
      RUN: if (beat) begin
        remaining_d = remaining_q - C_XFER_SIZE_WIDTH'(1);
        beats_d = beats_q + C_XFER_SIZE_WIDTH'(1);
        err_d = err_q | (s_axis_tlast != m_axis_tlast);
        state_d = m_axis_tlast ? DONE : RUN;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      remaining_q <= '0;
      beats_q <= '0;
      const_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      remaining_q <= remaining_d;
      beats_q <= beats_d;
      const_q <= const_d;
      err_q <= err_d;
    end
  end
`ifdef AXONERVE_KVS_ADDER_CTRL_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_d = start ? '0 : (run && s_axis_tvalid && !m_axis_tready && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge aclk) begin
    if (areset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign ctrl_stall_cycles = stall_q;
`else
  assign ctrl_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_axonerve_kvs_rtl_adder_ctrl.sv
// tb_axonerve_kvs_rtl_adder_ctrl: directed self-checking bench for the adder transfer sequencer
module tb_axonerve_kvs_rtl_adder_ctrl;
  logic aclk = 1'b0, areset = 1'b1;
  logic ctrl_start = 1'b0;
  logic [31:0] ctrl_xfer_beats = '0, ctrl_constant_in = '0;
  logic ctrl_busy, ctrl_done, ctrl_err_tlast;
  logic [31:0] ctrl_beats_done, ctrl_stall_cycles, adder_constant;
  logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [511:0] s_axis_tdata = '0, m_axis_tdata, pat;
  logic [63:0] s_axis_tkeep = '1, m_axis_tkeep;
  logic m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  int npass = 0, ntot = 0;
  always #5 aclk = ~aclk;
  axonerve_kvs_rtl_adder_ctrl dut (
    .aclk(aclk), .areset(areset), .ctrl_start(ctrl_start), .ctrl_xfer_beats(ctrl_xfer_beats),
    .ctrl_constant_in(ctrl_constant_in), .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done),
    .ctrl_err_tlast(ctrl_err_tlast), .ctrl_beats_done(ctrl_beats_done), .ctrl_stall_cycles(ctrl_stall_cycles),
    .adder_constant(adder_constant), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast)
  );
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask
  task automatic go(input logic [31:0] n, input logic [31:0] c);
    ctrl_start = 1'b1;
    ctrl_xfer_beats = n;
    ctrl_constant_in = c;
    cyc();
    ctrl_start = 1'b0;
  endtask
  initial begin
    logic [2:0] rdy_seq [6];
    int taken;
    rdy_seq = '{1, 0, 0, 1, 0, 1};
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    cyc();
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    cyc();
    chk("rst_busy", ctrl_busy, 0);
    chk("rst_done", ctrl_done, 0);
    chk("rst_err", ctrl_err_tlast, 0);
    chk("rst_beats", ctrl_beats_done, 0);
    chk("rst_stall", ctrl_stall_cycles, 0);
    chk("rst_const", adder_constant, 0);
    areset = 1'b0;
    #1;
    chk("idle_tready", s_axis_tready, 0);
    // 1: four back-to-back beats
    go(4, 32'h10);
    chk("t1_busy", ctrl_busy, 1);
    chk("t1_setup_tvalid", m_axis_tvalid, 0);
    chk("t1_const", adder_constant, 32'h10);
    cyc();
    for (int i = 1; i <= 4; i++) begin
      s_axis_tlast = (i == 4);
      pat = {16{32'hA5A50000 + i}};
      s_axis_tdata = pat;
      #1;
      chk($sformatf("t1_tvalid%0d", i), m_axis_tvalid, 1);
      chk($sformatf("t1_tready%0d", i), s_axis_tready, 1);
      chk($sformatf("t1_tlast%0d", i), m_axis_tlast, i == 4);
      chk($sformatf("t1_tdata%0d", i), m_axis_tdata, {16{32'hA5A50000 + i}});
      cyc();
    end
    s_axis_tlast = 1'b0;
    chk("t1_done", ctrl_done, 1);
    chk("t1_done_tvalid", m_axis_tvalid, 0);
    chk("t1_beats", ctrl_beats_done, 4);
    chk("t1_err", ctrl_err_tlast, 0);
    cyc();
    chk("t1_done_pulse", ctrl_done, 0);
    chk("t1_busy_off", ctrl_busy, 0);
    chk("t1_const_hold", adder_constant, 32'h10);
    // 2: backpressure from the adder
    go(3, 32'h20);
    cyc();
    taken = 0;
    for (int i = 0; i < 6; i++) begin
      m_axis_tready = rdy_seq[i][0];
      s_axis_tlast = rdy_seq[i][0] && taken == 2;
      #1;
      chk($sformatf("t2_tready%0d", i), s_axis_tready, rdy_seq[i][0]);
      chk($sformatf("t2_tlast%0d", i), m_axis_tlast, taken == 2);
      if (rdy_seq[i][0]) taken++;
      cyc();
    end
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    chk("t2_done", ctrl_done, 1);
    chk("t2_beats", ctrl_beats_done, 3);
    chk("t2_err", ctrl_err_tlast, 0);
`ifdef AXONERVE_KVS_ADDER_CTRL_STALL_CNT_EN
    chk("t2_stall", ctrl_stall_cycles, 3);
`else
    chk("t2_stall", ctrl_stall_cycles, 0);
`endif
    cyc();
    // 3: zero-beat call
    go(0, 32'h99);
    chk("t3_done", ctrl_done, 1);
    chk("t3_tvalid", m_axis_tvalid, 0);
    chk("t3_beats", ctrl_beats_done, 0);
    chk("t3_const", adder_constant, 32'h20);
    chk("t3_stall", ctrl_stall_cycles, 0);
    cyc();
    chk("t3_idle", ctrl_busy, 0);
    // 4: early upstream tlast
    go(2, 32'h5);
    cyc();
    s_axis_tlast = 1'b1;
    #1;
    chk("t4_tlast1", m_axis_tlast, 0);
    cyc();
    chk("t4_err_set", ctrl_err_tlast, 1);
    chk("t4_tlast2", m_axis_tlast, 1);
    cyc();
    s_axis_tlast = 1'b0;
    chk("t4_done", ctrl_done, 1);
    chk("t4_beats", ctrl_beats_done, 2);
    cyc();
    chk("t4_err_sticky", ctrl_err_tlast, 1);
    // 5: reset mid-run
    go(8, 32'h7);
    chk("t4_err_clear", ctrl_err_tlast, 0);
    cyc();
    cyc();
    cyc();
    cyc();
    chk("t5_beats3", ctrl_beats_done, 3);
    areset = 1'b1;
    #1;
    chk("t5_rst_tready", s_axis_tready, 0);
    chk("t5_rst_tvalid", m_axis_tvalid, 0);
    cyc();
    areset = 1'b0;
    chk("t5_busy", ctrl_busy, 0);
    chk("t5_done", ctrl_done, 0);
    chk("t5_beats", ctrl_beats_done, 0);
    cyc();
    chk("t5_no_done", ctrl_done, 0);
    go(1, 32'h3);
    cyc();
    s_axis_tlast = 1'b1;
    #1;
    chk("t5_tlast", m_axis_tlast, 1);
    cyc();
    chk("t5_redo_done", ctrl_done, 1);
    chk("t5_redo_beats", ctrl_beats_done, 1);
    chk("t5_redo_err", ctrl_err_tlast, 0);
    cyc();
    // 6: start held through a transfer, then a pulse during RUN
    ctrl_start = 1'b1;
    ctrl_xfer_beats = 1;
    ctrl_constant_in = 32'h11;
    cyc();
    cyc();
    chk("t6_run", s_axis_tready, 1);
    cyc();
    chk("t6_done", ctrl_done, 1);
    cyc();
    chk("t6_idle", ctrl_busy, 0);
    cyc();
    ctrl_start = 1'b0;
    chk("t6_restart", ctrl_busy, 1);
    chk("t6_const", adder_constant, 32'h11);
    cyc();
    ctrl_start = 1'b1;
    ctrl_xfer_beats = 5;
    #1;
    chk("t6_run2_tlast", m_axis_tlast, 1);
    cyc();
    ctrl_start = 1'b0;
    chk("t6_done2", ctrl_done, 1);
    chk("t6_beats2", ctrl_beats_done, 1);
    cyc();
    cyc();
    chk("t6_no_queue", ctrl_busy, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
